// File: rtl/vsm_ctrl_pkg.sv
// Shared definitions for the VSM control sequencer: state encoding, opcodes,
// the strobe bundle and the instruction-length helper.
package vsm_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH_A = 3'd1;
    localparam logic [2:0] ST_FETCH_M = 3'd2;
    localparam logic [2:0] ST_DECODE  = 3'd3;
    localparam logic [2:0] ST_EXEC_A  = 3'd4;
    localparam logic [2:0] ST_EXEC_B  = 3'd5;
    localparam logic [2:0] ST_PAUSE   = 3'd6;
    localparam logic [2:0] ST_HALT    = 3'd7;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_STA = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;
    localparam logic [3:0] OP_JZ  = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic clear_ir;
        logic latch_ir;
        logic enable_ir;
        logic enable_pc;
        logic inc_pc;
        logic load_pc;
        logic latch_mar;
        logic mem_read;
        logic mem_write;
        logic enable_acc;
        logic latch_acc;
        logic alu_sub;
        logic latch_out;
        logic halted;
    } strobes_t;

    // Cycles from FETCH_A to instruction end; HLT stops after DECODE.
    function automatic logic [2:0] instr_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: instr_len = 3'd5;
            OP_HLT:                         instr_len = 3'd3;
            default:                        instr_len = 3'd4;
        endcase
    endfunction

    function automatic logic needs_exec_b(input logic [3:0] op);
        needs_exec_b = (instr_len(op) == 3'd5);
    endfunction

endpackage

// File: rtl/vsm_ctrl_decode.sv
// Moore strobe decode: every datapath strobe is a pure function of the
// sequencer state and the opcode/zero values captured in DECODE.
module vsm_ctrl_decode
    import vsm_ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] op_q,
    input  logic       z_q,
    output strobes_t   strobes
);

    always_comb begin
        // NOTE: defaulting every field first keeps this block free of latches.
        strobes = '0;
        case (state)
            ST_IDLE: strobes.clear_ir = 1'b1;
            ST_FETCH_A: begin
                strobes.enable_pc = 1'b1;
                strobes.latch_mar = 1'b1;
            end
            ST_FETCH_M: begin
                strobes.mem_read = 1'b1;
                strobes.latch_ir = 1'b1;
                strobes.inc_pc   = 1'b1;
            end
            ST_EXEC_A: begin
                case (op_q)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                        strobes.enable_ir = 1'b1;
                        strobes.latch_mar = 1'b1;
                    end
                    OP_JMP: begin
                        strobes.enable_ir = 1'b1;
                        strobes.load_pc   = 1'b1;
                    end
                    OP_JZ: begin
                        strobes.enable_ir = 1'b1;
                        strobes.load_pc   = z_q;
                    end
                    OP_OUT: begin
                        strobes.enable_acc = 1'b1;
                        strobes.latch_out  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC_B: begin
                case (op_q)
                    OP_LDA, OP_ADD: begin
                        strobes.mem_read  = 1'b1;
                        strobes.latch_acc = 1'b1;
                    end
                    OP_SUB: begin
                        strobes.mem_read  = 1'b1;
                        strobes.latch_acc = 1'b1;
                        strobes.alu_sub   = 1'b1;
                    end
                    OP_STA: begin
                        strobes.enable_acc = 1'b1;
                        strobes.mem_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: strobes.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/vsm_control_sequencer.sv
// VSM control sequencer: fetch/decode/execute state machine with single-step
// support, a retired-instruction counter and Moore-decoded datapath strobes.
module vsm_control_sequencer
    import vsm_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             MainClock,
    input  logic             ClearN,
    input  logic             Run,
    input  logic             StepMode,
    input  logic             Step,
    input  logic [3:0]       Opcode,
    input  logic             Zero,
    output logic             ClearInstrReg,
    output logic             LatchInstrReg,
    output logic             EnableInstrReg,
    output logic             EnablePC,
    output logic             IncPC,
    output logic             LoadPC,
    output logic             LatchMAR,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             EnableAcc,
    output logic             LatchAcc,
    output logic             AluSub,
    output logic             LatchOut,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] after_instr;
    logic [3:0] op_q;
    logic       z_q;
    logic       step_q;
    logic       step_rise;
    logic       instr_end;
    strobes_t   strobes;

    // step_q follows Step in every state, so an edge seen outside PAUSE is gone by then.
    assign step_rise = Step & ~step_q;
    assign instr_end = ((state == ST_EXEC_A) && !needs_exec_b(op_q)) || (state == ST_EXEC_B);
    assign after_instr = StepMode ? ST_PAUSE : (Run ? ST_FETCH_A : ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (Run) state_next = ST_FETCH_A;
            ST_FETCH_A: state_next = ST_FETCH_M;
            ST_FETCH_M: state_next = ST_DECODE;
            ST_DECODE:  state_next = (Opcode == OP_HLT) ? ST_HALT : ST_EXEC_A;
            ST_EXEC_A:  state_next = needs_exec_b(op_q) ? ST_EXEC_B : after_instr;
            ST_EXEC_B:  state_next = after_instr;
            ST_PAUSE: begin
                if (!Run)           state_next = ST_IDLE;
                else if (step_rise) state_next = ST_FETCH_A;
            end
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge MainClock or negedge ClearN) begin
        if (!ClearN) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            z_q    <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_next;
            step_q <= Step;
            if (state == ST_DECODE) begin
                op_q <= Opcode;
                z_q  <= Zero;
            end
        end
    end

    always_ff @(posedge MainClock or negedge ClearN) begin
        if (!ClearN) begin
            InstrCount <= '0;
        end else if (instr_end) begin
            InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    vsm_ctrl_decode u_decode (
        .state   (state),
        .op_q    (op_q),
        .z_q     (z_q),
        .strobes (strobes)
    );

    assign ClearInstrReg  = strobes.clear_ir;
    assign LatchInstrReg  = strobes.latch_ir;
    assign EnableInstrReg = strobes.enable_ir;
    assign EnablePC       = strobes.enable_pc;
    assign IncPC          = strobes.inc_pc;
    assign LoadPC         = strobes.load_pc;
    assign LatchMAR       = strobes.latch_mar;
    assign MemRead        = strobes.mem_read;
    assign MemWrite       = strobes.mem_write;
    assign EnableAcc      = strobes.enable_acc;
    assign LatchAcc       = strobes.latch_acc;
    assign AluSub         = strobes.alu_sub;
    assign LatchOut       = strobes.latch_out;
    assign Halted         = strobes.halted;

endmodule

// File: tb/tb_vsm_control_sequencer.sv
// Self-checking bench for vsm_control_sequencer: randomized instruction stream
// checked cycle by cycle against a per-instruction strobe timeline model.
module tb_vsm_control_sequencer;

    localparam int CNT_W = 8;

    // Bench-side bit positions of the packed strobe vector.
    localparam logic [13:0] V_CLR  = 14'h2000;
    localparam logic [13:0] V_LIR  = 14'h1000;
    localparam logic [13:0] V_EIR  = 14'h0800;
    localparam logic [13:0] V_EPC  = 14'h0400;
    localparam logic [13:0] V_INC  = 14'h0200;
    localparam logic [13:0] V_LPC  = 14'h0100;
    localparam logic [13:0] V_MAR  = 14'h0080;
    localparam logic [13:0] V_MRD  = 14'h0040;
    localparam logic [13:0] V_MWR  = 14'h0020;
    localparam logic [13:0] V_EACC = 14'h0010;
    localparam logic [13:0] V_LACC = 14'h0008;
    localparam logic [13:0] V_SUB  = 14'h0004;
    localparam logic [13:0] V_OUT  = 14'h0002;
    localparam logic [13:0] V_HLT  = 14'h0001;

    logic             MainClock = 1'b0;
    logic             ClearN    = 1'b0;
    logic             Run       = 1'b0;
    logic             StepMode  = 1'b0;
    logic             Step      = 1'b0;
    logic [3:0]       Opcode    = 4'h0;
    logic             Zero      = 1'b0;
    logic             ClearInstrReg, LatchInstrReg, EnableInstrReg;
    logic             EnablePC, IncPC, LoadPC, LatchMAR;
    logic             MemRead, MemWrite;
    logic             EnableAcc, LatchAcc, AluSub, LatchOut, Halted;
    logic [CNT_W-1:0] InstrCount;
    logic [13:0]      obs;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    always #5 MainClock = ~MainClock;

    vsm_control_sequencer #(.CNT_W(CNT_W)) dut (
        .MainClock      (MainClock),
        .ClearN         (ClearN),
        .Run            (Run),
        .StepMode       (StepMode),
        .Step           (Step),
        .Opcode         (Opcode),
        .Zero           (Zero),
        .ClearInstrReg  (ClearInstrReg),
        .LatchInstrReg  (LatchInstrReg),
        .EnableInstrReg (EnableInstrReg),
        .EnablePC       (EnablePC),
        .IncPC          (IncPC),
        .LoadPC         (LoadPC),
        .LatchMAR       (LatchMAR),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .EnableAcc      (EnableAcc),
        .LatchAcc       (LatchAcc),
        .AluSub         (AluSub),
        .LatchOut       (LatchOut),
        .Halted         (Halted),
        .InstrCount     (InstrCount)
    );

    assign obs = {ClearInstrReg, LatchInstrReg, EnableInstrReg, EnablePC, IncPC, LoadPC,
                  LatchMAR, MemRead, MemWrite, EnableAcc, LatchAcc, AluSub, LatchOut, Halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Cycle k of an instruction, counted from its FETCH_A cycle.
    function automatic logic [13:0] expected(input logic [3:0] op, input int k, input logic z);
        case (k)
            0: return V_EPC | V_MAR;
            1: return V_MRD | V_LIR | V_INC;
            3: case (op)
                   4'h1, 4'h2, 4'h3, 4'h4: return V_EIR | V_MAR;
                   4'h5:                   return V_EIR | V_LPC;
                   4'h6:                   return z ? (V_EIR | V_LPC) : V_EIR;
                   4'h7:                   return V_EACC | V_OUT;
                   default:                return 14'h0;
               endcase
            4: case (op)
                   4'h1, 4'h3: return V_MRD | V_LACC;
                   4'h2:       return V_EACC | V_MWR;
                   4'h4:       return V_MRD | V_LACC | V_SUB;
                   default:    return 14'h0;
               endcase
            default: return 14'h0;
        endcase
    endfunction

    function automatic int length_of(input logic [3:0] op);
        if (op == 4'hF) return 3;
        if (op >= 4'h1 && op <= 4'h4) return 5;
        return 4;
    endfunction

    // Called at the negedge of a FETCH_A cycle; leaves at the negedge of the
    // cycle after the instruction (or mid-cycle if aborted by reset).
    // zmode: 0 random Zero, 1 Zero=1 in DECODE/0 in EXEC_A, 2 the opposite.
    task automatic run_instr(input logic [3:0] op, input logic end_run, input logic end_step,
                             input int step_drop_k, input int step_raise_k, input int abort_k,
                             input int zmode);
        int   len;
        logic z;
        len = length_of(op);
        z   = 1'b0;
        check("count_at_fetch", 32'(InstrCount), 32'(cnt_model));
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge MainClock);
            check($sformatf("strobes_op%h_k%0d", op, k), 32'(obs), 32'(expected(op, k, z)));
            if (k == abort_k) begin
                ClearN = 1'b0;
                #1;
                check("abort_strobes", 32'(obs), 32'(V_CLR));
                check("abort_count", 32'(InstrCount), 32'd0);
                cnt_model = '0;
                return;
            end
            Opcode = (k == 2) ? op : 4'($urandom);
            Zero   = 1'($urandom_range(0, 1));
            if (k == 2 && zmode == 1) Zero = 1'b1;
            if (k == 2 && zmode == 2) Zero = 1'b0;
            if (k == 3 && zmode == 1) Zero = 1'b0;
            if (k == 3 && zmode == 2) Zero = 1'b1;
            if (k == 2) z = Zero;
            if (k == step_drop_k)  Step = 1'b0;
            if (k == step_raise_k) Step = 1'b1;
            if (k == len - 1) begin
                Run      = end_run;
                StepMode = end_step;
            end
        end
        if (op != 4'hF) cnt_model++;
        @(negedge MainClock);
    endtask

    task automatic hold_cycles(input string tag, input logic [13:0] want, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(obs), 32'(want));
            @(negedge MainClock);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic       go;
        int         idle;

        repeat (2) @(negedge MainClock);
        check("reset_strobes", 32'(obs), 32'(V_CLR));
        check("reset_count", 32'(InstrCount), 32'd0);
        Run = 1'b1;
        @(negedge MainClock);
        check("reset_hold", 32'(obs), 32'(V_CLR));
        ClearN = 1'b1;
        @(negedge MainClock);

        run_instr(4'h1, 1'b1, 1'b0, -1, -1, -1, 0);
        check("lda_count", 32'(InstrCount), 32'd1);
        run_instr(4'h6, 1'b1, 1'b0, -1, -1, -1, 1);
        run_instr(4'h6, 1'b1, 1'b0, -1, -1, -1, 2);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 14));
            go = ($urandom_range(0, 3) != 0);
            run_instr(op, go, 1'b0, -1, -1, -1, 0);
            if (!go) begin
                idle = $urandom_range(0, 2);
                for (int j = 0; j <= idle; j++) begin
                    check("idle_after_run_low", 32'(obs), 32'(V_CLR));
                    if (j == idle) Run = 1'b1;
                    @(negedge MainClock);
                end
            end
        end

        // Single-step: pause holds, a 3-cycle Step pulse gives one instruction.
        run_instr(4'h0, 1'b1, 1'b1, -1, -1, -1, 0);
        hold_cycles("pause_hold", 14'h0, 10);
        check("pause_count", 32'(InstrCount), 32'(cnt_model));
        Step = 1'b1;
        @(negedge MainClock);
        run_instr(4'h0, 1'b1, 1'b1, 2, -1, -1, 0);
        hold_cycles("pause_after_step", 14'h0, 4);
        check("step_count", 32'(InstrCount), 32'(cnt_model));

        // Step edge during EXEC_A must not advance out of the next PAUSE.
        Step = 1'b1;
        @(negedge MainClock);
        run_instr(4'hA, 1'b1, 1'b1, 1, 3, -1, 0);
        hold_cycles("pause_stale_edge", 14'h0, 4);
        Step = 1'b0;
        hold_cycles("pause_step_low", 14'h0, 1);
        Step = 1'b1;
        @(negedge MainClock);
        run_instr(4'h7, 1'b0, 1'b1, 1, -1, -1, 0);
        check("pause_with_run_low", 32'(obs), 32'(14'h0));
        @(negedge MainClock);
        check("pause_to_idle", 32'(obs), 32'(V_CLR));
        StepMode = 1'b0;
        Run      = 1'b1;
        @(negedge MainClock);

        // HLT: halted for 50 cycles whatever the inputs do, then async clear.
        run_instr(4'h3, 1'b1, 1'b0, -1, -1, -1, 0);
        run_instr(4'hF, 1'b1, 1'b0, -1, -1, -1, 0);
        for (int i = 0; i < 50; i++) begin
            check("halt_hold", 32'(obs), 32'(V_HLT));
            Run      = 1'($urandom_range(0, 1));
            StepMode = 1'($urandom_range(0, 1));
            Step     = 1'($urandom_range(0, 1));
            Opcode   = 4'($urandom);
            @(negedge MainClock);
        end
        check("halt_count", 32'(InstrCount), 32'(cnt_model));
        ClearN = 1'b0;
        #1;
        check("halt_clear_strobes", 32'(obs), 32'(V_CLR));
        check("halt_clear_count", 32'(InstrCount), 32'd0);
        cnt_model = '0;
        @(negedge MainClock);
        ClearN   = 1'b1;
        Run      = 1'b1;
        StepMode = 1'b0;
        Step     = 1'b0;
        @(negedge MainClock);

        // Reset during EXEC_B of STA drops MemWrite without a clock edge.
        run_instr(4'h4, 1'b1, 1'b0, -1, -1, -1, 0);
        run_instr(4'h2, 1'b1, 1'b0, -1, -1, 4, 0);
        @(negedge MainClock);
        ClearN = 1'b1;
        Run    = 1'b1;
        @(negedge MainClock);

        // 256 NOP-class instructions wrap the 8-bit counter back to 0.
        for (int i = 0; i < 256; i++) begin
            if (i == 0) op = 4'hA;
            else if ($urandom_range(0, 1) == 0) op = 4'h0;
            else op = 4'($urandom_range(8, 14));
            run_instr(op, 1'b1, 1'b0, -1, -1, -1, 0);
        end
        check("wrap_count", 32'(InstrCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
